// File: rtl/simframe_pkg.sv
// Shared constants, error-bit indices and state encoding for the simulated-frame generator/checker pair.
package simframe_pkg;

    localparam int DEF_DATA_WIDTH     = 512;
    localparam int DEF_PATTERN_WIDTH  = 32;
    localparam int DEF_CELLS_PER_ROW  = 2048;
    localparam int DEF_ROWS_PER_FRAME = 2048;
    localparam int CELLS_PER_FRAME    = DEF_CELLS_PER_ROW * DEF_ROWS_PER_FRAME;

    localparam int ERR_LANE  = 0;
    localparam int ERR_DATA  = 1;
    localparam int ERR_TLAST = 2;
    localparam int ERR_W     = 3;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_RUN  = 1'b1
    } state_t;

    function automatic logic [31:0] sat_inc32(input logic [31:0] v);
        return (v == 32'hFFFF_FFFF) ? v : v + 32'd1;
    endfunction

endpackage

// File: rtl/simframe_check_if.sv
// AXI-Stream link carrying the replicated-pattern frame data into the checker.
interface simframe_check_if
    import simframe_pkg::*;
#(
    parameter int DATA_WIDTH = DEF_DATA_WIDTH
);
    logic [DATA_WIDTH-1:0] tdata;
    logic                  tvalid;
    logic                  tready;
    logic                  tlast;

    modport master (output tdata, output tvalid, output tlast, input tready);
    modport slave  (input tdata, input tvalid, input tlast, output tready);
endinterface

// File: rtl/simframe_lfsr.sv
// 16-bit Galois LFSR, reloads SEED on reset and steps while en is high; exposes bit 0.
module simframe_lfsr #(
    parameter logic [15:0] SEED = 16'hACE1,
    parameter logic [15:0] TAPS = 16'hB400
) (
    input  logic clk,
    input  logic reset,
    input  logic en,
    output logic q0
);
    logic [15:0] st;

    always_ff @(posedge clk) begin
        if (reset) begin
            st <= SEED;
        end else if (en) begin
            st <= st[0] ? ((st >> 1) ^ TAPS) : (st >> 1);
        end
    end

    assign q0 = st[0];
endmodule

// File: rtl/simframe_check.sv
// Frame checker: verifies lane replication, per-frame pattern, TLAST placement and row/frame length.
// Latency: status (counters, flags, frame_done) updates 1 cycle after the beat.
// Backpressure: none by default; SIMFRAME_CHECK_THROTTLE_EN gates tready with an LFSR bit.
module simframe_check
    import simframe_pkg::*;
#(
    parameter int DATA_WIDTH     = DEF_DATA_WIDTH,
    parameter int PATTERN_WIDTH  = DEF_PATTERN_WIDTH,
    parameter int CELLS_PER_ROW  = DEF_CELLS_PER_ROW,
    parameter int ROWS_PER_FRAME = DEF_ROWS_PER_FRAME
) (
    input  logic                     clk,
    input  logic                     reset,
    simframe_check_if.slave          axis_in,
    input  logic                     clear,
    output logic                     frame_done,
    output logic [31:0]              frame_count,
    output logic [31:0]              error_count,
    output logic [ERR_W-1:0]         err_flags,
    output logic [PATTERN_WIDTH-1:0] cur_pattern,
    output logic                     in_frame
);
    localparam int CYCLES_PER_ROW = CELLS_PER_ROW / (DATA_WIDTH / 8);
    localparam int NLANES         = DATA_WIDTH / PATTERN_WIDTH;
    localparam int CYC_W          = (CYCLES_PER_ROW > 1) ? $clog2(CYCLES_PER_ROW) : 1;
    localparam int ROW_W          = (ROWS_PER_FRAME > 1) ? $clog2(ROWS_PER_FRAME) : 1;
    localparam logic [CYC_W-1:0] CYC_LAST = CYC_W'(CYCLES_PER_ROW - 1);
    localparam logic [ROW_W-1:0] ROW_LAST = ROW_W'(ROWS_PER_FRAME - 1);

    state_t                   state, state_nxt;
    logic [CYC_W-1:0]         cyc, cyc_nxt, cur_cyc;
    logic [ROW_W-1:0]         row, row_nxt, cur_row;
    logic [PATTERN_WIDTH-1:0] pat_nxt;
    logic [PATTERN_WIDTH-1:0] lane0;
    logic [NLANES-1:0]        lane_mis;
    logic [ERR_W-1:0]         err_vec;
    logic                     ready;
    logic                     beat;
    logic                     row_end;
    logic                     frame_end;

`ifdef SIMFRAME_CHECK_THROTTLE_EN
    logic lfsr_bit;

    simframe_lfsr #(
        .SEED (16'hACE1),
        .TAPS (16'hB400)
    ) u_lfsr (
        .clk   (clk),
        .reset (reset),
        .en    (1'b1),
        .q0    (lfsr_bit)
    );

    assign ready = !reset & lfsr_bit;
`else
    assign ready = !reset;
`endif

    assign axis_in.tready = ready;
    assign beat           = axis_in.tvalid & ready;
    assign lane0          = axis_in.tdata[PATTERN_WIDTH-1:0];
    assign in_frame       = (state == ST_RUN);

    for (genvar g = 0; g < NLANES; g++) begin : g_lane
        assign lane_mis[g] = (axis_in.tdata[g*PATTERN_WIDTH +: PATTERN_WIDTH] != lane0);
    end

    // The capture beat in IDLE is position cyc=0/row=0 of the new frame.
    always_comb begin
        cur_cyc   = (state == ST_RUN) ? cyc : '0;
        cur_row   = (state == ST_RUN) ? row : '0;
        row_end   = axis_in.tlast | (cur_cyc == CYC_LAST);
        frame_end = row_end & (cur_row == ROW_LAST);
        err_vec            = '0;
        err_vec[ERR_LANE]  = |lane_mis;
        err_vec[ERR_DATA]  = (state == ST_RUN) && (lane0 != cur_pattern);
        err_vec[ERR_TLAST] = axis_in.tlast != (cur_cyc == CYC_LAST);
    end

    always_comb begin
        state_nxt = state;
        cyc_nxt   = cyc;
        row_nxt   = row;
        pat_nxt   = cur_pattern;
        if (beat) begin
            if (state == ST_IDLE) begin
                pat_nxt   = lane0;
                state_nxt = ST_RUN;
            end
            if (row_end) begin
                cyc_nxt = '0;
                row_nxt = cur_row + 1'b1;
            end else begin
                cyc_nxt = cur_cyc + 1'b1;
                row_nxt = cur_row;
            end
            if (frame_end) begin
                state_nxt = ST_IDLE;
                row_nxt   = '0;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state       <= ST_IDLE;
            cyc         <= '0;
            row         <= '0;
            cur_pattern <= '0;
            frame_done  <= 1'b0;
            frame_count <= '0;
            error_count <= '0;
            err_flags   <= '0;
        end else begin
            state       <= state_nxt;
            cyc         <= cyc_nxt;
            row         <= row_nxt;
            cur_pattern <= pat_nxt;
            frame_done  <= beat & frame_end;
            if (clear) begin
                frame_count <= '0;
                error_count <= '0;
                err_flags   <= '0;
            end else if (beat) begin
                if (frame_end) begin
                    frame_count <= frame_count + 32'd1;
                end
                if (|err_vec) begin
                    error_count <= sat_inc32(error_count);
                    err_flags   <= err_flags | err_vec;
                end
            end
        end
    end
endmodule

// File: tb/tb_simframe_check.sv
// Directed self-checking bench for simframe_check: 4 lanes x 16b, 4 beats/row, 4 rows/frame.
module tb_simframe_check;
    localparam int DW  = 64;
    localparam int PW  = 16;
    localparam int CPR = 32;
    localparam int RPF = 4;

    logic        clk = 1'b0;
    logic        reset;
    logic        clear;
    logic        frame_done;
    logic [31:0] frame_count;
    logic [31:0] error_count;
    logic [2:0]  err_flags;
    logic [15:0] cur_pattern;
    logic        in_frame;

    int checks      = 0;
    int failures    = 0;
    int done_pulses = 0;
    int tready_low  = 0;
    int gap         = 0;

    simframe_check_if #(.DATA_WIDTH(DW)) axis ();

    simframe_check #(
        .DATA_WIDTH     (DW),
        .PATTERN_WIDTH  (PW),
        .CELLS_PER_ROW  (CPR),
        .ROWS_PER_FRAME (RPF)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .axis_in     (axis),
        .clear       (clear),
        .frame_done  (frame_done),
        .frame_count (frame_count),
        .error_count (error_count),
        .err_flags   (err_flags),
        .cur_pattern (cur_pattern),
        .in_frame    (in_frame)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (frame_done) done_pulses++;
        if (!reset && !axis.tready) tready_low++;
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [63:0] rep(input logic [15:0] p);
        return {p, p, p, p};
    endfunction

    // One handshake; returns 1 time unit after the accepting edge.
    task automatic beat(input logic [63:0] d, input logic last);
        logic ok;
        int   n;
        ok = 1'b0;
        n  = 0;
        axis.tvalid = 1'b1;
        axis.tdata  = d;
        axis.tlast  = last;
        while (!ok && n < 200) begin
            @(negedge clk);
            ok = axis.tready;
            @(posedge clk);
            #1;
            n++;
        end
        if (!ok) chk("beat_handshake", {63'd0, ok}, 64'd1);
        axis.tvalid = 1'b0;
        axis.tlast  = 1'b0;
        repeat (gap) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic send_frame(input logic [15:0] p, input int bad_idx, input logic [63:0] bad_dat);
        for (int i = 0; i < 16; i++) begin
            beat((i == bad_idx) ? bad_dat : rep(p), (i % 4) == 3);
        end
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic do_clear(input string tag);
        clear = 1'b1;
        idle(1);
        clear = 1'b0;
        chk({tag, "_fc"}, frame_count, 0);
        chk({tag, "_ec"}, error_count, 0);
        chk({tag, "_flags"}, err_flags, 0);
    endtask

    initial begin
        reset       = 1'b1;
        clear       = 1'b0;
        axis.tvalid = 1'b0;
        axis.tdata  = '0;
        axis.tlast  = 1'b0;
        idle(3);
        chk("rst_tready", axis.tready, 0);
        chk("rst_fc", frame_count, 0);
        chk("rst_ec", error_count, 0);
        chk("rst_flags", err_flags, 0);
        chk("rst_pat", cur_pattern, 0);
        chk("rst_in_frame", in_frame, 0);
        chk("rst_done", frame_done, 0);
        reset = 1'b0;
        idle(1);

        // 1: two clean frames with different patterns
        send_frame(16'h1234, -1, '0);
        send_frame(16'hBEEF, -1, '0);
        chk("t1_done_now", frame_done, 1);
        idle(2);
        chk("t1_done_pulses", done_pulses, 2);
        chk("t1_fc", frame_count, 2);
        chk("t1_ec", error_count, 0);
        chk("t1_flags", err_flags, 0);
        chk("t1_pat", cur_pattern, 16'hBEEF);
        chk("t1_in_frame", in_frame, 0);

        // 2: lane 2 zeroed on the sixth beat
        do_clear("t2_clr");
        send_frame(16'h1234, 5, 64'h1234_0000_1234_1234);
        idle(2);
        chk("t2_ec", error_count, 1);
        chk("t2_flags", err_flags, 3'b001);
        chk("t2_fc", frame_count, 1);

        // 3: early TLAST on the second beat of row 0, frame is 14 beats
        do_clear("t3_clr");
        beat(rep(16'h1234), 1'b0);
        beat(rep(16'h1234), 1'b1);
        chk("t3_ec_early", error_count, 1);
        for (int i = 0; i < 11; i++) beat(rep(16'h1234), (i % 4) == 3);
        chk("t3_in_frame", in_frame, 1);
        chk("t3_fc_pre", frame_count, 0);
        beat(rep(16'h1234), 1'b1);
        idle(2);
        chk("t3_fc", frame_count, 1);
        chk("t3_ec", error_count, 1);
        chk("t3_flags", err_flags, 3'b100);
        chk("t3_in_frame_end", in_frame, 0);

        // 4: wrong pattern on all lanes of beat 9, back-to-back then gapped
        do_clear("t4_clr");
        send_frame(16'h1234, 8, rep(16'h5555));
        idle(2);
        chk("t4_flags", err_flags, 3'b010);
        chk("t4_ec", error_count, 1);
        chk("t4_fc", frame_count, 1);
        do_clear("t4g_clr");
        gap = 2;
        send_frame(16'h1234, 8, rep(16'h5555));
        gap = 0;
        idle(2);
        chk("t4g_flags", err_flags, 3'b010);
        chk("t4g_ec", error_count, 1);
        chk("t4g_fc", frame_count, 1);

        // 5: reset mid-frame, then clear coincident with an erroneous beat
        do_clear("t5_clr");
        for (int i = 0; i < 7; i++) beat(rep(16'h1234), (i % 4) == 3);
        reset = 1'b1;
        idle(2);
        reset = 1'b0;
        chk("t5_rst_in_frame", in_frame, 0);
        send_frame(16'h2222, -1, '0);
        idle(2);
        chk("t5_fc", frame_count, 1);
        chk("t5_ec", error_count, 0);
        chk("t5_in_frame", in_frame, 0);
        chk("t5_pat", cur_pattern, 16'h2222);
        clear = 1'b1;
        beat(64'h1234_1234_0000_1234, 1'b0);
        clear = 1'b0;
        chk("t5_clr_ec", error_count, 0);
        chk("t5_clr_flags", err_flags, 0);
        chk("t5_clr_fc", frame_count, 0);
        chk("t5_clr_in_frame", in_frame, 1);
        chk("t5_clr_pat", cur_pattern, 16'h1234);
        for (int i = 1; i < 16; i++) beat(rep(16'h1234), (i % 4) == 3);
        idle(2);
        chk("t5_fc2", frame_count, 1);
        chk("t5_ec2", error_count, 0);

        // 6: three clean frames (throttled in the LFSR build)
        do_clear("t6_clr");
        send_frame(16'hA5A5, -1, '0);
        send_frame(16'h0F0F, -1, '0);
        send_frame(16'h7E7E, -1, '0);
        idle(2);
        chk("t6_fc", frame_count, 3);
        chk("t6_ec", error_count, 0);
        chk("t6_pat", cur_pattern, 16'h7E7E);
`ifdef SIMFRAME_CHECK_THROTTLE_EN
        chk("t6_tready_toggles", {63'd0, tready_low > 0}, 64'd1);
`else
        chk("t6_tready_always", tready_low, 0);
`endif
        chk("total_done_pulses", done_pulses, 11);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
